// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial add/subtract engine
//
// Purpose: FSM state encoding and operation select codes used by serial_adder_ctrl.
// Ports:   none (package).

package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
//
// Purpose: combinational one-bit full adder; the only arithmetic in the serial engine.
// Ports:
//   i_bit1, i_bit2 : addend bits
//   i_cin          : carry in
//   o_sum          : sum bit
//   o_cout         : carry out

module full_adder (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_bit1 ^ i_bit2 ^ i_cin;
  assign o_cout = (i_bit1 & i_bit2) | (i_cin & (i_bit1 ^ i_bit2));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit add/subtract engine with valid/ready handshakes
//
// Purpose: accepts an operand pair in IDLE, processes one bit per clock LSB first through a
//          single full_adder for WIDTH cycles, then holds sum/carry/overflow in DONE until taken.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_sub  : operands and op select (0 add, 1 subtract)
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   out_sum, out_cout   : result bits and final carry (subtract: 1 = no borrow)
//   out_ovf             : signed overflow
//   busy                : high in RUN or DONE

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_cout;
  logic             r_ovf;
  logic             w_accept;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  full_adder u_full_adder (
    .i_bit1 (r_a_sh[0]),
    .i_bit2 (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next_state = ST_RUN;
      ST_RUN:  if (w_last)    w_next_state = ST_DONE;
      ST_DONE: if (out_ready) w_next_state = ST_IDLE;
      default:                w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  end

  // Datapath. Subtraction is A + ~B + 1: B is inverted on accept and the +1 enters as the
  // initial carry. The sum register doubles as the result register, so it only moves in RUN
  // and otherwise holds the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= in_a;
      r_b_sh  <= in_b ^ {WIDTH{in_sub}};
      r_carry <= (in_sub == OP_SUB);
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= {w_fa_sum, r_sum_sh[WIDTH-1:1]};
      r_carry  <= w_fa_cout;
      if (w_last) begin
        // Signed overflow: carry into the MSB differs from carry out of it.
        r_ovf  <= r_carry ^ w_fa_cout;
        r_cout <= w_fa_cout;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_sum  = r_sum_sh;
  assign out_cout = r_cout;
  assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl

module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic sub);
    int unsigned full;
    int          ia;
    int          ib;
    int          ires;
    logic        ovf;
    logic [WIDTH-1:0] nb;
    ia = int'($signed(a));
    ib = int'($signed(b));
    nb = ~b;
    if (sub) begin
      full = int'(a) + int'(nb) + 1;
      ires = ia - ib;
    end else begin
      full = int'(a) + int'(b);
      ires = ia + ib;
    end
    ovf = (ires > (2 ** (WIDTH - 1)) - 1) || (ires < -(2 ** (WIDTH - 1)));
    return {ovf, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  // Behavioural timeline: an accepted op yields its result WIDTH edges later, and the result
  // stays presented until the consumer takes it.
  int               m_left = -1;
  bit               m_done = 1'b0;
  bit               armed  = 1'b0;
  logic [WIDTH+1:0] m_pend = '0;
  logic [WIDTH+1:0] m_out  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= -1;
      m_done <= 1'b0;
      m_out  <= '0;
      armed  <= 1'b1;
    end else if (m_left < 0 && !m_done) begin
      if (in_valid) begin
        m_pend <= ref_op(in_a, in_b, in_sub);
        m_left <= WIDTH;
      end
    end else if (m_left > 1) begin
      m_left <= m_left - 1;
    end else if (m_left == 1) begin
      m_left <= -1;
      m_done <= 1'b1;
      m_out  <= m_pend;
    end else if (out_ready) begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", 32'(busy), 32'((m_left > 0) || m_done));
      check("in_ready", 32'(in_ready), 32'(!((m_left > 0) || m_done)));
      check("out_valid", 32'(out_valid), 32'(m_done));
      if (m_left < 0) begin
        check("out_sum", 32'(out_sum), 32'(m_out[WIDTH-1:0]));
        check("out_cout", 32'(out_cout), 32'(m_out[WIDTH]));
        check("out_ovf", 32'(out_ovf), 32'(m_out[WIDTH+1]));
      end
    end
  end

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                       input bit toggle, input int hold, input bit lit,
                       input logic [WIDTH-1:0] e_sum, input logic e_cout, input logic e_ovf);
    int k;
    bit seen;
    @(negedge clk);
    check("ready_before_op", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (k = 1; k <= WIDTH + 4; k++) begin
      if (toggle) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_a      = WIDTH'($urandom);
        in_b      = WIDTH'($urandom);
        in_sub    = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", seen ? 32'(k) : 32'd0, 32'(WIDTH));
    if (lit) begin
      check("lit_sum", 32'(out_sum), 32'(e_sum));
      check("lit_cout", 32'(out_cout), 32'(e_cout));
      check("lit_ovf", 32'(out_ovf), 32'(e_ovf));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      if (lit) check("hold_sum", 32'(out_sum), 32'(e_sum));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("after_take_valid", 32'(out_valid), 32'd0);
    check("after_take_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = OP_ADD;
    out_ready = 1'b0;

    check("model_100p27", 32'(ref_op(8'd100, 8'd27, OP_ADD)), 32'({2'b00, 8'd127}));
    check("model_200p100", 32'(ref_op(8'd200, 8'd100, OP_ADD)), 32'({2'b01, 8'd44}));
    check("model_80m1", 32'(ref_op(8'h80, 8'h01, OP_SUB)), 32'({2'b11, 8'h7F}));

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_cout", 32'(out_cout), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;

    do_op(8'd100, 8'd27,  OP_ADD, 1'b0, 0, 1'b1, 8'd127, 1'b0, 1'b0);
    do_op(8'd200, 8'd100, OP_ADD, 1'b0, 0, 1'b1, 8'd44,  1'b1, 1'b0);
    do_op(8'd100, 8'd100, OP_ADD, 1'b0, 0, 1'b1, 8'd200, 1'b0, 1'b1);
    do_op(8'd5,   8'd7,   OP_SUB, 1'b0, 0, 1'b1, 8'd254, 1'b0, 1'b0);
    do_op(8'h80,  8'h01,  OP_SUB, 1'b0, 0, 1'b1, 8'h7F,  1'b1, 1'b1);
    do_op(8'd100, 8'd27,  OP_ADD, 1'b0, 20, 1'b1, 8'd127, 1'b0, 1'b0);
    do_op(8'd50,  8'd60,  OP_SUB, 1'b1, 2, 1'b1, 8'd246, 1'b0, 1'b0);

    // Reset during RUN: three RUN edges pass, then reset hits on the fourth.
    @(negedge clk);
    in_a = 8'd9; in_b = 8'd9; in_sub = OP_ADD; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    do_op(8'd1, 8'd1, OP_ADD, 1'b0, 0, 1'b1, 8'd2, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, '0, 1'b0, 1'b0);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
